// File: rtl/if_pc_ctrl_if.sv
// Fetch-control bundle between the fetch controller and its surroundings.
// stall_cnt exists only when IF_PC_STALL_CNT_EN is defined.
interface if_pc_ctrl_if #(
    parameter int INSTMEM_LOG2_DEEP = 8,
    parameter int REG_ADDR_W        = 5
);
    logic                         start;
    logic                         halt_req;
    logic                         branch_taken;
    logic [INSTMEM_LOG2_DEEP-1:0] branch_target;
    logic                         idex_mem_read;
    logic [REG_ADDR_W-1:0]        idex_rd;
    logic [REG_ADDR_W-1:0]        ifid_rs1;
    logic [REG_ADDR_W-1:0]        ifid_rs2;
    logic [INSTMEM_LOG2_DEEP-1:0] pc_out;
    logic                         wb_ff_out;
    logic                         hazard;
    logic                         flush;
    logic                         running;
`ifdef IF_PC_STALL_CNT_EN
    logic [15:0]                  stall_cnt;
`endif

    // master: pipeline/control side driving requests; slave: the fetch controller
    modport master (
        output start, halt_req, branch_taken, branch_target,
               idex_mem_read, idex_rd, ifid_rs1, ifid_rs2,
`ifdef IF_PC_STALL_CNT_EN
        input  stall_cnt,
`endif
        input  pc_out, wb_ff_out, hazard, flush, running
    );

    modport slave (
        input  start, halt_req, branch_taken, branch_target,
               idex_mem_read, idex_rd, ifid_rs1, ifid_rs2,
`ifdef IF_PC_STALL_CNT_EN
        output stall_cnt,
`endif
        output pc_out, wb_ff_out, hazard, flush, running
    );
endinterface

// File: rtl/if_pc_ctrl.sv
// Fetch-side PC owner: run/halt FSM, branch redirect and load-use stall detection.
// Optional saturating stall counter enabled by IF_PC_STALL_CNT_EN.
module if_pc_ctrl #(
    parameter int                           INSTMEM_LOG2_DEEP = 8,
    parameter int                           REG_ADDR_W        = 5,
    parameter logic [INSTMEM_LOG2_DEEP-1:0] RESET_PC          = '0
) (
    input  logic       CLK,
    input  logic       RST,
    if_pc_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e                       state_q, state_d;
    logic [INSTMEM_LOG2_DEEP-1:0] pc_q, pc_d;
    logic                         wb_q, wb_d;
    logic                         running;
    logic                         raw_hz;
    logic                         hazard;

    assign running = (state_q == ST_RUN);
    // Register 0 is hard-wired, so a load targeting it can never create a dependency.
    assign raw_hz  = running & bus.idex_mem_read & (bus.idex_rd != '0) &
                     ((bus.idex_rd == bus.ifid_rs1) | (bus.idex_rd == bus.ifid_rs2));
    assign hazard  = raw_hz & ~bus.branch_taken & ~bus.halt_req;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wb_d    = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                if (bus.start && !bus.halt_req) begin
                    state_d = ST_RUN;
                    wb_d    = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.halt_req) begin
                    state_d = ST_HALT;
                end else if (bus.branch_taken) begin
                    pc_d = bus.branch_target;
                    wb_d = 1'b1;
                end else if (hazard) begin
                    wb_d = wb_q;
                end else begin
                    pc_d = pc_q + 1'b1;
                    wb_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            wb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wb_q    <= wb_d;
        end
    end

    assign bus.pc_out    = pc_q;
    assign bus.wb_ff_out = wb_q;
    assign bus.hazard    = hazard;
    assign bus.flush     = running & bus.branch_taken;
    assign bus.running   = running;

`ifdef IF_PC_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule
